// File: rtl/memory_seq_pkg.sv
// Shared op codes, FSM encoding and address helpers for the memory access sequencer.
package memory_seq_pkg;

  typedef enum logic [1:0] {
    OP_FETCH = 2'b00,   // read at (seg<<4)+ip, advance ip
    OP_RD    = 2'b01,   // read at op_addr
    OP_WR    = 2'b10,   // write op_wdata at op_addr
    OP_WR_IP = 2'b11    // write op_wdata at (seg<<4)+ip, advance ip
  } op_sel_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_ACCESS = 2'b01,
    ST_WAIT   = 2'b10,
    ST_RESP   = 2'b11
  } state_e;

  // Widest segment/offset supported by phys_addr; callers truncate the result.
  localparam int SEG_MAX_W  = 32;
  localparam int PHYS_MAX_W = SEG_MAX_W + 4;

  // Real-mode style physical address. Carry out of the caller's address width is
  // dropped by the caller's truncating cast, giving the FFFFF -> 00000 wrap.
  function automatic logic [PHYS_MAX_W-1:0] phys_addr(input logic [SEG_MAX_W-1:0] seg,
                                                      input logic [SEG_MAX_W-1:0] off);
    return {seg, 4'h0} + {4'h0, off};
  endfunction

  function automatic logic op_is_read(input op_sel_e sel);
    return (sel == OP_FETCH) || (sel == OP_RD);
  endfunction

  function automatic logic op_uses_ip(input op_sel_e sel);
    return (sel == OP_FETCH) || (sel == OP_WR_IP);
  endfunction

endpackage

// File: rtl/address_history_ring.sv
// Ring of the most recently issued memory addresses with an indexed, newest-first read port.
module address_history_ring
  import memory_seq_pkg::*;
#(
  parameter int ADDR_W = 20,
  parameter int DEPTH  = 20,
  parameter int IDX_W  = $clog2(DEPTH),
  parameter int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic              clk_i,
  input  logic              reset_n_i,
  input  logic              wr_en_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic              clear_i,
  input  logic [IDX_W-1:0]  rd_idx_i,
  output logic [ADDR_W-1:0] rd_addr_o,
  output logic [CNT_W-1:0]  count_o
);

  localparam int                SUM_W    = IDX_W + 2;
  localparam logic [IDX_W-1:0]  LAST_PTR = IDX_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0]  FULL_CNT = CNT_W'(DEPTH);

  logic [DEPTH-1:0][ADDR_W-1:0] mem_q;
  logic [IDX_W-1:0]             wr_ptr_q;
  logic [CNT_W-1:0]             cnt_q;
  logic [SUM_W-1:0]             rd_sum;

  // Write / clear. A clear coinciding with a write restarts the ring with that write as entry 0.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      mem_q    <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
    end else if (clear_i) begin
      if (wr_en_i) begin
        mem_q[0] <= wr_addr_i;
        wr_ptr_q <= IDX_W'(1);
        cnt_q    <= CNT_W'(1);
      end else begin
        wr_ptr_q <= '0;
        cnt_q    <= '0;
      end
    end else if (wr_en_i) begin
      mem_q[wr_ptr_q] <= wr_addr_i;
      wr_ptr_q        <= (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + 1'b1;
      if (cnt_q != FULL_CNT) cnt_q <= cnt_q + 1'b1;
    end
  end

  // Newest-first lookup: slot = (wr_ptr - 1 - idx) mod DEPTH; entries past the count read as 0.
  always_comb begin
    rd_sum = SUM_W'(wr_ptr_q) + SUM_W'(DEPTH - 1) - SUM_W'(rd_idx_i);
    if (rd_sum >= SUM_W'(DEPTH)) rd_sum = rd_sum - SUM_W'(DEPTH);
    rd_addr_o = '0;
    if (CNT_W'(rd_idx_i) < cnt_q) rd_addr_o = mem_q[rd_sum[IDX_W-1:0]];
  end

  assign count_o = cnt_q;

endmodule

// File: rtl/memory_access_sequencer.sv
// Segmented-memory access engine: one op per handshake, one registered strobe per op,
// fixed-latency read return, IP tracking and a log of issued addresses.
module memory_access_sequencer
  import memory_seq_pkg::*;
#(
  parameter int ADDR_W     = 20,
  parameter int DATA_W     = 16,
  parameter int OFF_W      = 16,
  parameter int RD_LAT     = 1,
  parameter int IP_STEP    = 2,
  parameter int HIST_DEPTH = 20
) (
  input  logic                            clk_i,
  input  logic                            reset_n_i,
  input  logic                            op_valid_i,
  output logic                            op_ready_o,
  input  logic [1:0]                      op_sel_i,
  input  logic [ADDR_W-1:0]               op_addr_i,
  input  logic [DATA_W-1:0]               op_wdata_i,
  input  logic [OFF_W-1:0]                seg_i,
  input  logic                            ip_load_i,
  input  logic [OFF_W-1:0]                ip_load_val_i,
  output logic [OFF_W-1:0]                ip_o,
  output logic                            mem_re_o,
  output logic                            mem_we_o,
  output logic [ADDR_W-1:0]               mem_addr_o,
  output logic [DATA_W-1:0]               mem_wdata_o,
  input  logic [DATA_W-1:0]               mem_rdata_i,
  output logic                            rsp_valid_o,
  output logic [DATA_W-1:0]               rsp_data_o,
  output logic [ADDR_W-1:0]               rsp_addr_o,
  input  logic                            hist_clear_i,
  input  logic [$clog2(HIST_DEPTH)-1:0]   hist_idx_i,
  output logic [ADDR_W-1:0]               hist_addr_o,
  output logic [$clog2(HIST_DEPTH+1)-1:0] hist_count_o
);

  localparam int WCNT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

  state_e              state_q, state_d;
  op_sel_e             sel;
  logic                accept;
  logic                last_wait;
  logic [ADDR_W-1:0]   ip_addr;
  logic                is_rd_q;
  logic                ip_op_q;
  logic [WCNT_W-1:0]   wait_cnt_q;
  logic                mem_re_q, mem_we_q;
  logic [ADDR_W-1:0]   mem_addr_q;
  logic [DATA_W-1:0]   mem_wdata_q;
  logic [DATA_W-1:0]   rsp_data_q;
  logic [OFF_W-1:0]    ip_q;

  assign sel     = op_sel_e'(op_sel_i);
  // Held low while reset is asserted so the upstream unit never sees a ready during reset.
  assign op_ready_o = (state_q == ST_IDLE) && reset_n_i;
  assign accept     = op_valid_i && op_ready_o;
  assign ip_addr    = ADDR_W'(phys_addr(SEG_MAX_W'(seg_i), SEG_MAX_W'(ip_q)));
  assign last_wait  = (wait_cnt_q == WCNT_W'(RD_LAT - 1));

  // FSM state register
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) state_q <= ST_IDLE;
    else            state_q <= state_d;
  end

  // FSM next state: reads spend RD_LAT cycles in WAIT, writes go straight to RESP
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:   if (accept) state_d = ST_ACCESS;
      ST_ACCESS: state_d = is_rd_q ? ST_WAIT : ST_RESP;
      ST_WAIT:   if (last_wait) state_d = ST_RESP;
      ST_RESP:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Capture the op at accept, fire its single strobe, and collect the response data
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      mem_re_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      is_rd_q     <= 1'b0;
      ip_op_q     <= 1'b0;
      wait_cnt_q  <= '0;
      rsp_data_q  <= '0;
    end else begin
      mem_re_q <= accept && op_is_read(sel);
      mem_we_q <= accept && !op_is_read(sel);
      if (accept) begin
        is_rd_q     <= op_is_read(sel);
        ip_op_q     <= op_uses_ip(sel);
        mem_addr_q  <= op_uses_ip(sel) ? ip_addr : op_addr_i;
        mem_wdata_q <= op_is_read(sel) ? '0 : op_wdata_i;
      end
      if (state_q == ST_ACCESS)    wait_cnt_q <= '0;
      else if (state_q == ST_WAIT) wait_cnt_q <= wait_cnt_q + 1'b1;
      // Read data is valid in the last WAIT cycle; writes report zero.
      if (state_q == ST_ACCESS && !is_rd_q)      rsp_data_q <= '0;
      else if (state_q == ST_WAIT && last_wait)  rsp_data_q <= mem_rdata_i;
    end
  end

  // Instruction pointer: an explicit load beats the post-access increment
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i)                           ip_q <= '0;
    else if (ip_load_i)                       ip_q <= ip_load_val_i;
    else if (state_q == ST_ACCESS && ip_op_q) ip_q <= ip_q + OFF_W'(IP_STEP);
  end

  address_history_ring #(
    .ADDR_W (ADDR_W),
    .DEPTH  (HIST_DEPTH)
  ) u_hist (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .wr_en_i   (state_q == ST_ACCESS),
    .wr_addr_i (mem_addr_q),
    .clear_i   (hist_clear_i),
    .rd_idx_i  (hist_idx_i),
    .rd_addr_o (hist_addr_o),
    .count_o   (hist_count_o)
  );

  assign ip_o        = ip_q;
  assign mem_re_o    = mem_re_q;
  assign mem_we_o    = mem_we_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;
  assign rsp_valid_o = (state_q == ST_RESP);
  assign rsp_data_o  = rsp_data_q;
  assign rsp_addr_o  = mem_addr_q;

endmodule

// File: tb/tb_memory_access_sequencer.sv
// Directed bench: an op-level timeline model predicts strobes, responses, IP and history per cycle.
module tb_memory_access_sequencer;

  localparam int ADDR_W = 20, DATA_W = 16, OFF_W = 16, RD_LAT = 1, IP_STEP = 2, HD = 20;

  logic              clk = 1'b0, reset_n = 1'b0;
  logic              op_valid = 1'b0, op_ready;
  logic [1:0]        op_sel = '0;
  logic [ADDR_W-1:0] op_addr = '0;
  logic [DATA_W-1:0] op_wdata = '0;
  logic [OFF_W-1:0]  seg = '0;
  logic              ip_load = 1'b0;
  logic [OFF_W-1:0]  ip_load_val = '0, ip;
  logic              mem_re, mem_we;
  logic [ADDR_W-1:0] mem_addr, rsp_addr, hist_addr;
  logic [DATA_W-1:0] mem_wdata, mem_rdata, rsp_data;
  logic              rsp_valid;
  logic              hist_clear = 1'b0;
  logic [4:0]        hist_idx = '0;
  logic [4:0]        hist_count;

  memory_access_sequencer #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .OFF_W(OFF_W),
    .RD_LAT(RD_LAT), .IP_STEP(IP_STEP), .HIST_DEPTH(HD)
  ) dut (
    .clk_i(clk), .reset_n_i(reset_n), .op_valid_i(op_valid), .op_ready_o(op_ready),
    .op_sel_i(op_sel), .op_addr_i(op_addr), .op_wdata_i(op_wdata), .seg_i(seg),
    .ip_load_i(ip_load), .ip_load_val_i(ip_load_val), .ip_o(ip),
    .mem_re_o(mem_re), .mem_we_o(mem_we), .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata),
    .mem_rdata_i(mem_rdata), .rsp_valid_o(rsp_valid), .rsp_data_o(rsp_data),
    .rsp_addr_o(rsp_addr), .hist_clear_i(hist_clear), .hist_idx_i(hist_idx),
    .hist_addr_o(hist_addr), .hist_count_o(hist_count)
  );

  always #5 clk = ~clk;

  // ---------------- external memory stand-in ----------------
  logic [15:0] tbm [4096];
  bit          tbv [4096];
  logic [15:0] rd_pipe [RD_LAT];
  always @(posedge clk) begin
    if (mem_we) begin
      tbm[mem_addr[11:0]] <= mem_wdata;
      tbv[mem_addr[11:0]] <= 1'b1;
    end
    rd_pipe[0] <= !mem_re ? 16'hDEAD :
                  tbv[mem_addr[11:0]] ? tbm[mem_addr[11:0]] : {4'hA, mem_addr[11:0]};
    for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign mem_rdata = rd_pipe[RD_LAT-1];

  // ---------------- model ----------------
  int total = 0, bad = 0, cyc = 0;
  bit [1:0]    e_stb [int];   // 01 read strobe, 10 write strobe, keyed by cycle
  logic [19:0] e_sa  [int];
  logic [15:0] e_swd [int];
  logic [15:0] e_rd  [int];   // expected response data keyed by cycle
  logic [19:0] e_ra  [int];
  bit          e_inc [int];   // cycles whose closing edge advances IP
  logic [15:0] m_ip = '0;
  logic [19:0] hq[$];         // issued addresses, newest at back
  logic [15:0] mdl_mem [logic [19:0]];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic [19:0] phys(input logic [15:0] s, input logic [15:0] o);
    logic [19:0] r;
    r = {s, 4'h0} + {4'h0, o};
    return r;
  endfunction

  function automatic logic [15:0] mrd(input logic [19:0] a);
    if (mdl_mem.exists(a)) return mdl_mem[a];
    return {4'hA, a[11:0]};
  endfunction

  task automatic model_reset();
    e_stb.delete(); e_sa.delete(); e_swd.delete(); e_rd.delete(); e_ra.delete(); e_inc.delete();
    m_ip = '0;
    hq.delete();
  endtask

  // Model state advance at each rising edge
  initial forever begin
    @(posedge clk);
    if (reset_n) begin
      if (e_sa.exists(cyc)) begin
        if (hist_clear) hq.delete();
        hq.push_back(e_sa[cyc]);
        if (hq.size() > HD) void'(hq.pop_front());
      end else if (hist_clear) hq.delete();
      if (ip_load)                m_ip = ip_load_val;
      else if (e_inc.exists(cyc)) m_ip = m_ip + 16'(IP_STEP);
    end
    cyc = cyc + 1;
  end

  // Per-cycle comparison against the model
  initial forever begin
    @(negedge clk);
    if (e_stb.exists(cyc)) begin
      chk("mem_re", {31'd0, mem_re}, {31'd0, e_stb[cyc][0]});
      chk("mem_we", {31'd0, mem_we}, {31'd0, e_stb[cyc][1]});
      chk("mem_addr", {12'd0, mem_addr}, {12'd0, e_sa[cyc]});
      if (e_stb[cyc][1]) chk("mem_wdata", {16'd0, mem_wdata}, {16'd0, e_swd[cyc]});
    end else begin
      chk("mem_re_idle", {31'd0, mem_re}, 32'd0);
      chk("mem_we_idle", {31'd0, mem_we}, 32'd0);
    end
    if (e_rd.exists(cyc)) begin
      chk("rsp_valid", {31'd0, rsp_valid}, 32'd1);
      chk("rsp_data", {16'd0, rsp_data}, {16'd0, e_rd[cyc]});
      chk("rsp_addr", {12'd0, rsp_addr}, {12'd0, e_ra[cyc]});
    end else chk("rsp_valid_idle", {31'd0, rsp_valid}, 32'd0);
    chk("ip", {16'd0, ip}, {16'd0, m_ip});
    chk("hist_count", {27'd0, hist_count}, hq.size());
  end

  // ---------------- stimulus helpers ----------------
  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Present an op, wait for accept, record its predicted timeline; returns in the ACCESS cycle.
  task automatic do_op(input logic [1:0] sel, input logic [19:0] a_in, input logic [15:0] wd,
                       input logic [15:0] sg, output int p);
    logic [19:0] a;
    bit rd;
    int n;
    op_sel = sel; op_addr = a_in; op_wdata = wd; seg = sg; op_valid = 1'b1;
    n = 0;
    while (!op_ready && n < 40) begin step(1); n++; end
    chk("accept", {31'd0, op_ready}, 32'd1);
    rd = (sel == 2'b00) || (sel == 2'b01);
    a  = (sel == 2'b01 || sel == 2'b10) ? a_in : phys(sg, m_ip);
    p  = cyc + 1;
    e_stb[p] = rd ? 2'b01 : 2'b10;
    e_sa[p]  = a;
    e_swd[p] = wd;
    if (sel == 2'b00 || sel == 2'b11) e_inc[p] = 1'b1;
    if (rd) begin
      e_rd[p+1+RD_LAT] = mrd(a);
      e_ra[p+1+RD_LAT] = a;
    end else begin
      e_rd[p+1]  = '0;
      e_ra[p+1]  = a;
      mdl_mem[a] = wd;
    end
    step(1);
    op_valid = 1'b0;
    op_sel = 2'($urandom); op_addr = 20'($urandom); op_wdata = 16'($urandom); seg = 16'($urandom);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (!op_ready && n < 40) begin step(1); n++; end
    chk("idle", {31'd0, op_ready}, 32'd1);
  endtask

  task automatic load_ip(input logic [15:0] v);
    ip_load = 1'b1; ip_load_val = v;
    step(1);
    ip_load = 1'b0;
  endtask

  task automatic hchk(input string nm, input logic [4:0] idx, input logic [19:0] exp);
    hist_idx = idx;
    #1;
    chk(nm, {12'd0, hist_addr}, {12'd0, exp});
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int p, nrsp;
    step(3);
    chk("rst_ready", {31'd0, op_ready}, 32'd0);
    chk("rst_ip", {16'd0, ip}, 32'd0);
    chk("rst_re", {31'd0, mem_re}, 32'd0);
    chk("rst_we", {31'd0, mem_we}, 32'd0);
    chk("rst_rsp", {31'd0, rsp_valid}, 32'd0);
    chk("rst_addr", {12'd0, mem_addr}, 32'd0);
    chk("rst_hcnt", {27'd0, hist_count}, 32'd0);
    reset_n = 1'b1;
    #1;
    chk("ready_after_rst", {31'd0, op_ready}, 32'd1);

    // fetch with seg 0x1000, ip 0x0100
    load_ip(16'h0100);
    do_op(2'b00, '0, '0, 16'h1000, p);
    chk("fetch_re", {31'd0, mem_re}, 32'd1);
    chk("fetch_addr", {12'd0, mem_addr}, 32'h10100);
    step(1);
    chk("fetch_ip", {16'd0, ip}, 32'h0102);
    wait_idle();

    // write 0x00042 <- BEEF then read back; write responds in cycle 2, read in cycle 3
    do_op(2'b10, 20'h00042, 16'hBEEF, '0, p);
    chk("wr_we", {31'd0, mem_we}, 32'd1);
    step(1);
    chk("wr_rsp_c2", {31'd0, rsp_valid}, 32'd1);
    chk("wr_rsp_data", {16'd0, rsp_data}, 32'd0);
    wait_idle();
    do_op(2'b01, 20'h00042, 16'h1234, '0, p);
    step(1);
    chk("rd_no_rsp_c2", {31'd0, rsp_valid}, 32'd0);
    step(1);
    chk("rd_rsp_c3", {31'd0, rsp_valid}, 32'd1);
    chk("rd_rsp_data", {16'd0, rsp_data}, 32'hBEEF);
    step(1);
    chk("rd_ready_c4", {31'd0, op_ready}, 32'd1);
    do_op(2'b01, 20'h00123, '0, '0, p);
    wait_idle();
    do_op(2'b11, '0, 16'h5A5A, 16'h2000, p);
    chk("wrip_addr", {12'd0, mem_addr}, 32'h20102);
    wait_idle();

    // address wrap and IP wrap
    load_ip(16'hFFFE);
    do_op(2'b00, '0, '0, 16'hFFFF, p);
    chk("wrap_addr", {12'd0, mem_addr}, 32'h0FFEE);
    step(1);
    chk("wrap_ip", {16'd0, ip}, 32'h0000);
    wait_idle();

    // ip_load during ACCESS beats the increment
    do_op(2'b00, '0, '0, 16'h0300, p);
    ip_load = 1'b1; ip_load_val = 16'h0200;
    step(1);
    ip_load = 1'b0;
    chk("ld_wins_ip", {16'd0, ip}, 32'h0200);
    wait_idle();

    // history wrap: 25 fetches from 0x00000 stepping by 2
    load_ip(16'h0000);
    hist_clear = 1'b1;
    step(1);
    hist_clear = 1'b0;
    chk("hist_cleared", {27'd0, hist_count}, 32'd0);
    for (int k = 0; k < 25; k++) begin
      do_op(2'b00, '0, '0, 16'h0000, p);
      wait_idle();
    end
    chk("hist_full", {27'd0, hist_count}, 32'd20);
    hchk("hist_idx0", 5'd0, 20'h00030);
    hchk("hist_idx1", 5'd1, 20'h0002E);
    hchk("hist_idx19", 5'd19, 20'h0000A);
    hchk("hist_idx20", 5'd20, 20'h00000);

    // clear coinciding with ACCESS keeps the new address as entry 0
    do_op(2'b00, '0, '0, 16'h0000, p);
    hist_clear = 1'b1;
    step(1);
    hist_clear = 1'b0;
    chk("clr_acc_cnt", {27'd0, hist_count}, 32'd1);
    hchk("clr_acc_idx0", 5'd0, 20'h00032);
    hchk("clr_acc_idx1", 5'd1, 20'h00000);
    wait_idle();

    // reset during WAIT: nothing comes back
    do_op(2'b01, 20'h00042, '0, '0, p);
    step(1);
    reset_n = 1'b0;
    model_reset();
    #1;
    chk("rstw_re", {31'd0, mem_re}, 32'd0);
    chk("rstw_we", {31'd0, mem_we}, 32'd0);
    chk("rstw_rsp", {31'd0, rsp_valid}, 32'd0);
    step(2);
    reset_n = 1'b1;
    nrsp = 0;
    repeat (5) begin @(negedge clk); if (rsp_valid) nrsp++; end
    chk("rstw_no_rsp", nrsp, 32'd0);
    chk("rstw_ready", {31'd0, op_ready}, 32'd1);
    step(1);

    // reset during a write's ACCESS drops the strobe at once
    do_op(2'b10, 20'h00077, 16'h7777, '0, p);
    reset_n = 1'b0;
    model_reset();
    #1;
    chk("rsta_we", {31'd0, mem_we}, 32'd0);
    step(2);
    reset_n = 1'b1;
    step(1);

    // normal operation resumes
    do_op(2'b00, '0, '0, 16'h0001, p);
    chk("resume_addr", {12'd0, mem_addr}, 32'h00010);
    wait_idle();
    step(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
